// File: rtl/glb_stream_reader_pkg.sv
// glb_stream_reader_pkg: shared widths and FSM state type for the GLB stream reader
package glb_stream_reader_pkg;
  localparam int DATA_SIZE = 32;
  localparam int XID_BITS = 5;
  localparam int YID_BITS = 5;
  typedef enum logic [1:0] {IDLE, READ, FINISH} state_e;
endpackage

// File: rtl/glb_skid_fifo.sv
// glb_skid_fifo: 2-entry FIFO; head reads as zero while empty
module glb_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q;
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_q ^ push_i;
      rd_q  <= rd_q ^ pop_i;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end
  assign head_o  = (cnt_q == 2'd0) ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/glb_stream_reader.sv
// glb_stream_reader: reads a burst of GLB words and streams them out with ready/valid,
// limiting reads so buffered plus in-flight words never exceed the 2-entry FIFO.
module glb_stream_reader
  import glb_stream_reader_pkg::*;
#(
  parameter int LEN_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_base_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic [XID_BITS-1:0]  cmd_tag_X,
  input  logic [YID_BITS-1:0]  cmd_tag_Y,
  output logic [3:0]           glb_re,
  output logic [31:0]          glb_r_addr,
  input  logic [DATA_SIZE-1:0] glb_r_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [XID_BITS-1:0]  out_tag_X,
  output logic [YID_BITS-1:0]  out_tag_Y,
  output logic                 busy,
  output logic                 done
);
  state_e                state_q, state_d;
  logic [31:0]           addr_q;
  logic [LEN_BITS-1:0]   len_q, issued_q, acc_q;
  logic                  infl_q, pop, issue, accept, last;
  logic [1:0]            cnt;
  logic [2:0]            credit;
  glb_skid_fifo #(.W(DATA_SIZE)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (infl_q),
    .data_i  (glb_r_data),
    .pop_i   (pop),
    .head_o  (out_data),
    .count_o (cnt)
  );
  assign out_valid  = cnt != 2'd0;
  assign pop        = out_valid && out_ready;
  assign credit     = {1'b0, cnt} + {2'b0, infl_q} - {2'b0, pop};
  assign issue      = (state_q == READ) && (issued_q < len_q) && (credit < 3'd2);
  assign glb_re     = {4{issue}};
  assign glb_r_addr = addr_q;
  assign cmd_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign done       = state_q == FINISH;
  assign accept     = cmd_valid && cmd_ready;
  assign last       = pop && (acc_q == len_q - LEN_BITS'(1));
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? ((cmd_len == '0) ? FINISH : READ) : IDLE)
            : (state_q == READ) ? (last ? FINISH : READ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      acc_q     <= '0;
      infl_q    <= 1'b0;
      out_tag_X <= '0;
      out_tag_Y <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= issue;
      if (accept) begin
        addr_q    <= cmd_base_addr;
        len_q     <= cmd_len;
        issued_q  <= '0;
        acc_q     <= '0;
        out_tag_X <= cmd_tag_X;
        out_tag_Y <= cmd_tag_Y;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + 32'd4;
          issued_q <= issued_q + LEN_BITS'(1);
        end
        if (pop) acc_q <= acc_q + LEN_BITS'(1);
      end
    end
  end
endmodule
